secuenciador_melodia: RTL and testbench



---
 rtl/secuenciador_melodia.sv | 171 +++++++++++++++++
 tb/tb_secuenciador_melodia.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_melodia.sv
// secuenciador_melodia
// Melody sequencer that feeds the tone generator's 7-bit one-hot key bus.
// It steps through a fixed note table. Each note holds its key line for
// duration*TICK_DIV cycles, followed by GAP_CYC silent cycles. When idle,
// the manual keyboard is passed straight through to the output.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   play           start request (level-sampled, acted on only when idle)
//   stop           abort request, takes priority over play
//   teclas_manual  live key inputs, passed through while idle
//   teclas         registered key lines to the tone generator
//   busy           high while a melody is being played (LOAD/SOUND/GAP)
//   note_idx       current note-table index
//   done           one-cycle pulse at the natural end of the melody
//
// Build option:
//   SECUENCIA_LOOP_EN  when defined, the melody restarts from index 0 at its
//                      end instead of returning to idle (no done pulse).

module secuenciador_melodia #(
  parameter int TICK_DIV = 6250000,
  parameter int GAP_CYC  = 500000,
  parameter int MEL_LEN  = 32,
  localparam int IDX_W   = (MEL_LEN > 1) ? $clog2(MEL_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic             stop,
  input  logic [6:0]       teclas_manual,
  output logic [6:0]       teclas,
  output logic             busy,
  output logic [IDX_W-1:0] note_idx,
  output logic             done
);

  localparam int CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MEL_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SOUND = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state;
  logic [3:0]       unit_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       entry;
  logic             note_end;
  logic             mel_end;

  // Note table: [7:4] duration units (0 = end marker), [3] reserved,
  // [2:0] note (0 = rest, 1..7 = DO..SI).
  function automatic logic [7:0] note_table(input logic [IDX_W-1:0] idx);
    logic [7:0] e;
    case (32'(idx))
      0:       e = 8'h21;  // DO, 2 units
      1:       e = 8'h12;  // RE, 1 unit
      2:       e = 8'h10;  // rest, 1 unit
      3:       e = 8'h43;  // MI, 4 units
      default: e = 8'h00;  // end marker
    endcase
    note_table = e;
  endfunction

  // One-hot decode of the low nibble. Anything outside 1..7 (including a
  // set reserved bit) plays as a rest, so the bus can never carry two keys.
  function automatic logic [6:0] decode_note(input logic [3:0] n);
    logic [6:0] k;
    k = 7'd0;
    if (n != 4'd0 && n <= 4'd7) k = 7'd1 << (n - 4'd1);
    decode_note = k;
  endfunction

  always_comb begin
    entry    = note_table(note_idx);
    note_end = 1'b0;
    if (state == S_SOUND && cyc_cnt == CYC_LAST && unit_cnt == 4'd1 && GAP_CYC == 0)
      note_end = 1'b1;
    if (state == S_GAP && gap_cnt == GAP_LAST)
      note_end = 1'b1;
    // End of melody: an end marker reached in LOAD, or a note finishing at
    // the last table slot (the index is never allowed to wrap).
    mel_end = (state == S_LOAD && entry[7:4] == 4'd0) || (note_end && note_idx == IDX_LAST);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      teclas   <= 7'd0;
      note_idx <= '0;
      done     <= 1'b0;
      unit_cnt <= 4'd0;
      cyc_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != S_IDLE) begin
        state    <= S_IDLE;
        teclas   <= 7'd0;
        note_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (play && !stop) begin
              state    <= S_LOAD;
              note_idx <= '0;
              // Blank the bus on entry so manual chords never leak into
              // the busy window.
              teclas   <= 7'd0;
            end else begin
              teclas <= teclas_manual;
            end
          end
          S_LOAD: begin
            if (!mel_end) begin
              state    <= S_SOUND;
              teclas   <= decode_note(entry[3:0]);
              unit_cnt <= entry[7:4];
              cyc_cnt  <= '0;
            end
          end
          S_SOUND: begin
            if (cyc_cnt == CYC_LAST) begin
              cyc_cnt  <= '0;
              unit_cnt <= unit_cnt - 4'd1;
              if (unit_cnt == 4'd1) begin
                teclas <= 7'd0;
                if (GAP_CYC > 0) begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
                end
              end
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
          end
          default: state <= S_IDLE;
        endcase

        // Note completion and melody end override the per-state updates.
        if (mel_end) begin
          teclas   <= 7'd0;
          note_idx <= '0;
`ifdef SECUENCIA_LOOP_EN
          state    <= S_LOAD;
`else
          state    <= S_IDLE;
          done     <= 1'b1;
`endif
        end else if (note_end) begin
          note_idx <= note_idx + 1'b1;
          state    <= S_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_melodia.sv
// Testbench for secuenciador_melodia (TICK_DIV=4, GAP_CYC=2, MEL_LEN=32).
// A timeline model expands the note table into the per-cycle output sequence
// when a melody starts; a compare process checks the DUT on every cycle.

module tb_secuenciador_melodia;

  localparam int TICK_DIV = 4;
  localparam int GAP_CYC  = 2;
  localparam int MEL_LEN  = 32;
  localparam int IDX_W    = 5;

  logic             clk;
  logic             rst;
  logic             play;
  logic             stop;
  logic [6:0]       manual;
  logic [6:0]       teclas;
  logic             busy;
  logic [IDX_W-1:0] note_idx;
  logic             done;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  secuenciador_melodia #(
    .TICK_DIV(TICK_DIV),
    .GAP_CYC (GAP_CYC),
    .MEL_LEN (MEL_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .play         (play),
    .stop         (stop),
    .teclas_manual(manual),
    .teclas       (teclas),
    .busy         (busy),
    .note_idx     (note_idx),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]       t;
    logic             b;
    logic [IDX_W-1:0] i;
    logic             d;
  } obs_t;

  obs_t q[$];
  obs_t exp_o;

  function automatic logic [7:0] tbl(input int i);
    case (i)
      0:       return 8'h21;
      1:       return 8'h12;
      2:       return 8'h10;
      3:       return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  function automatic obs_t mk(input logic [6:0] t, input logic b, input int i, input logic d);
    obs_t o;
    o.t = t; o.b = b; o.i = IDX_W'(i); o.d = d;
    return o;
  endfunction

  // Expand one pass of the melody into the outputs seen after each edge,
  // starting with the edge after the one that entered the first LOAD.
  function automatic void gen_melody();
    int i;
    int dur;
    int nt;
    logic [7:0] e;
    logic [6:0] k;
    i = 0;
    while (1) begin
      e   = tbl(i);
      dur = int'(e[7:4]);
      nt  = int'(e[2:0]);
      if (dur == 0) break;
      k = (nt == 0) ? 7'd0 : 7'(1 << (nt - 1));
      for (int c = 0; c < dur * TICK_DIV; c++) q.push_back(mk(k, 1'b1, i, 1'b0));
      for (int c = 0; c < GAP_CYC; c++) q.push_back(mk(7'd0, 1'b1, i, 1'b0));
      if (i == MEL_LEN - 1) break;
      i++;
      q.push_back(mk(7'd0, 1'b1, i, 1'b0));
    end
`ifdef SECUENCIA_LOOP_EN
    q.push_back(mk(7'd0, 1'b1, 0, 1'b0));
`else
    q.push_back(mk(7'd0, 1'b0, 0, 1'b1));
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_o = '0;
    end else if (q.size() > 0) begin
      if (stop) begin
        q.delete();
        exp_o = '0;
      end else begin
        exp_o = q.pop_front();
`ifdef SECUENCIA_LOOP_EN
        if (q.size() == 0) gen_melody();
`endif
      end
    end else begin
      exp_o = mk(manual, 1'b0, 0, 1'b0);
      if (play && !stop) begin
        exp_o = mk(7'd0, 1'b1, 0, 1'b0);
        gen_melody();
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({teclas, busy, note_idx, done} !== exp_o) begin
        errors++;
        $display("FAIL cycle t=%0t: got teclas=%b busy=%b idx=%0d done=%b, expected teclas=%b busy=%b idx=%0d done=%b",
                 $time, teclas, busy, note_idx, done, exp_o.t, exp_o.b, exp_o.i, exp_o.d);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin
    int cnt1;
    int dn;
    int n;
    bit ok;
    rst = 1'b1; play = 1'b0; stop = 1'b0; manual = 7'd0;
    @(posedge clk);
    #1 started = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_teclas", 32'(teclas), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(note_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    rst = 1'b0;
    manual = 7'b0010000;
    @(negedge clk);
    check("passthru", 32'(teclas), 32'b0010000);

    // Full melody with the manual keys all pressed during playback.
    play = 1'b1; manual = 7'h7F;
    @(negedge clk);
    play = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    check("load_teclas", 32'(teclas), 32'd0);
    check("model_len", 32'(q.size()), 32'd45);
    n = 0;
    foreach (q[j]) if (q[j].t == 7'b0000100) n++;
    check("model_mi_cycles", 32'(n), 32'd16);
    cnt1 = 0; dn = 0; ok = 1'b0;
`ifdef SECUENCIA_LOOP_EN
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("loop_no_done", 32'(dn), 32'd0);
    check("loop_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'd0);
`else
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (teclas == 7'b0000001) cnt1++;
      if (done) dn++;
      if (!busy) begin ok = 1'b1; break; end
    end
    check("melody_ends", 32'(ok), 32'd1);
    check("do_cycles", 32'(cnt1), 32'd8);
    check("done_at_end", 32'(dn), 32'd1);
    check("end_idx", 32'(note_idx), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("manual_back", 32'(teclas), 32'h7F);
`endif

    // Stop in the third SOUND cycle of idx3.
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (note_idx == 5'd3 && teclas == 7'b0000100) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("reach_idx3", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_teclas", 32'(teclas), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_idx", 32'(note_idx), 32'd0);

    // play and stop together while idle.
    play = 1'b1; stop = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("play_stop_idle", 32'(busy), 32'd0);
    end
    play = 1'b0; stop = 1'b0;

    // Reset in the gap after idx1, then restart.
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (teclas == 7'b0000010) begin ok = 1'b1; break; end
    end
    check("reach_re", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (teclas == 7'd0) begin ok = 1'b1; break; end
    end
    check("reach_gap1", 32'(ok), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_teclas", 32'(teclas), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_idx", 32'(note_idx), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (teclas == 7'b0000001) begin ok = 1'b1; break; end
    end
    check("restart_first_note", 32'(ok), 32'd1);
    check("restart_idx", 32'(note_idx), 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // play held across melody ends.
    play = 1'b1;
    repeat (110) @(negedge clk);
    play = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      play   = ($urandom % 8) == 0;
      stop   = ($urandom % 100) == 0;
      rst    = ($urandom % 300) == 0;
      manual = 7'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; play = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
